memory_access: RTL and testbench
================================

# memory_access

Pipeline MEM stage of the RV32I core: takes the registered ALU result, store data, func3, opcode, rd and pc from the Execute stage and performs the data-memory load or store over a req/ack bus. It drives byte strobes, sign/zero-extends load data, stalls the pipe while a memory access is outstanding, and registers the write-back bundle. The same registered result/rd pair is returned to Execute as the MEM-to-EX forwarding source.

## Interface
- TIMEOUT, 16, cycles to wait for `i_dmem_ack` in WAIT before aborting the access.
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset; forces IDLE and clears all registered outputs.
- i_result  in  32  ALU result from Execute; this is the byte address for loads and stores.
- i_data_store  in  32  store data from Execute.
- i_pc  in  32  instruction pc.
- i_func3  in  3  width and sign selector.
- i_opcode  in  7  0000011 load, 0100011 store, 1100011 branch, 0000000 bubble.
- i_rd  in  5  destination register.
- o_dmem_req  out  1  access request.
- o_dmem_we  out  1  1 = store.
- o_dmem_addr  out  32  word address, `{addr[31:2],2'b00}`.
- o_dmem_wdata  out  32  store data, lane-replicated.
- o_dmem_wstrb  out  4  byte enables; 0 on loads.
- i_dmem_ack  in  1  access complete; `i_dmem_rdata` valid with it.
- i_dmem_rdata  in  32  word read data.
- o_stall  out  1  combinational; freezes IF/ID/EX.
- o_wb_result  out  32  registered write-back value; this is also the MEM-to-EX forward value.
- o_wb_rd  out  5  registered destination register.
- o_wb_we  out  1  registered register-write enable.
- o_wb_pc  out  32  registered pc.
- o_rd_mem  out  5  `o_wb_we ? o_wb_rd : 0`, the forward tag for Execute.
- o_fault  out  1  registered one-cycle pulse on a misaligned access, illegal func3, or timeout.

## Operation
- Operation classes:
  - mem-op: opcode is load or store.
  - non-mem: any other opcode.
  - write-back: opcode is not store, not branch and not bubble, and `i_rd != 0`.
- Legal func3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
  - any other value is a fault.
- Misaligned:
  - halfword access with `addr[0] = 1`.
  - word access with `addr[1:0] != 0`.
- Store strobes and data:
  - SB: `wstrb = 1 << addr[1:0]`, `wdata = {4{d[7:0]}}`.
  - SH: `wstrb = addr[1] ? 1100 : 0011`, `wdata = {2{d[15:0]}}`.
  - SW: `wstrb = 1111`, `wdata = d`.
- Load extraction: select the byte lane by `addr[1:0]` and the halfword lane by `addr[1]`. LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states: IDLE, WAIT.
- IDLE, non-mem op:
  - no request is issued.
  - next edge: `o_wb_result <= i_result`, plus rd, pc and the write-back enable.
- IDLE, faulting mem-op:
  - no request is issued.
  - next edge: `o_wb_we <= 0`, `o_fault <= 1`.
- IDLE, legal mem-op:
  - `o_dmem_req = 1` combinationally, driven from the i_* inputs.
  - If `i_dmem_ack` is high in the same cycle: complete. Next edge writes the extracted load data (or nothing for a store) to WB. No stall.
  - Otherwise: `o_stall = 1`. Next edge latches addr, we, wdata, wstrb, func3, rd and pc into internal registers, clears the timeout counter, enters WAIT and sets `o_wb_we <= 0` (bubble).
- WAIT:
  - request is driven from the latched registers, `o_dmem_req = 1`.
  - `o_stall = 1` until ack.
  - On `i_dmem_ack`: `o_stall = 0` that cycle. Next edge writes the completed result to WB and returns to IDLE.
  - Each cycle without ack increments the counter; `o_wb_we <= 0` each edge.
  - Timeout: when the counter reaches TIMEOUT-1 without ack, next edge sets `o_fault <= 1`, `o_wb_we <= 0` and returns to IDLE. The access is dropped.
- `i_dmem_ack` while `o_dmem_req = 0` is ignored.
- `o_fault` is cleared on the edge after it was set.

## Timing
- Reset:
  - state = IDLE, counter = 0, all o_wb_* = 0, `o_fault = 0`.
  - `o_dmem_req` is asserted only for a legal mem-op in IDLE; with a bubble/non-mem input (the post-reset Execute output) it reads 0.
  - rst asserted in WAIT drops the request immediately (asynchronous) and discards the latched access.
- Latency:
  - non-mem op and zero-wait mem-op: 1 cycle to WB.
  - ack after N wait cycles: N stall cycles, WB on the edge after ack.
- Request fields are stable from the first WAIT cycle until ack; a zero-wait access is sampled from the i_* inputs in its single cycle.
- `o_stall` is combinational from state, opcode and ack. There is no stall on the ack cycle, so Execute advances on that same edge.
- Counter width is `$clog2(TIMEOUT)`; it saturates and is cleared on entering WAIT.

## Test plan
- ADD result 0x1234, rd=5, no memory -> next cycle `o_wb_result = 0x1234`, `o_wb_we = 1`, `o_rd_mem = 5`, `o_dmem_req = 0`.
- SB data 0xAB at addr 0x1002, ack same cycle -> `wstrb = 0100`, `wdata = 0xABABABAB`, `o_dmem_addr = 0x1000`, `o_stall = 0`, next cycle `o_wb_we = 0`.
- LB at addr 0x1003, rdata 0x80xxxxxx, ack after 3 cycles -> `o_stall` high 3 cycles, then `o_wb_result = 0xFFFFFF80`; repeated as LBU -> 0x00000080.
- LW at addr 0x1002 -> no request, next cycle `o_fault = 1` for one cycle, `o_wb_we = 0`.
- LW with ack never returned, TIMEOUT=16 -> `o_stall` high 16 cycles, then `o_fault` pulse, back to IDLE, `o_stall = 0`.
- rst asserted in the 2nd WAIT cycle of LH -> `o_dmem_req = 0` immediately; after release IDLE, all outputs 0.

Source files
------------

// File: rtl/memory_access.sv
// MEM stage of the RV32I pipe: issues data-memory loads/stores over a req/ack
// bus, stalls the front end while an access is outstanding, registers write-back.
module memory_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_result,
  input  logic [31:0] i_data_store,
  input  logic [31:0] i_pc,
  input  logic [2:0]  i_func3,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_wstrb,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic [31:0] o_wb_result,
  output logic [4:0]  o_wb_rd,
  output logic        o_wb_we,
  output logic [31:0] o_wb_pc,
  output logic [4:0]  o_rd_mem,
  output logic        o_fault,
  output logic        dbg_state
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BUBBLE = 7'b0000000;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [31:0]    lat_addr;
  logic [31:0]    lat_wdata;
  logic [3:0]     lat_wstrb;
  logic           lat_we;
  logic [1:0]     lat_lo;
  logic [2:0]     lat_f3;
  logic [4:0]     lat_rd;
  logic [31:0]    lat_pc;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] rdata);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = rdata >> {a, 3'b000};
    b = shifted[7:0];
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return rdata;
    endcase
  endfunction

  logic        is_mem;
  logic        is_store;
  logic        in_fault;
  logic        in_go;
  logic        in_wb_we;
  logic [3:0]  in_wstrb;
  logic [31:0] in_wdata;

  assign is_store = (i_opcode == OP_STORE);
  assign is_mem   = (i_opcode == OP_LOAD) || is_store;
  assign in_fault = is_mem && (!f3_legal(is_store, i_func3) || misaligned(i_func3, i_result[1:0]));
  // Gated by rst so an access presented during reset never reaches the bus.
  assign in_go    = !rst && (state == IDLE) && is_mem && !in_fault;
  assign in_wb_we = (i_opcode != OP_STORE) && (i_opcode != OP_BRANCH) &&
                    (i_opcode != OP_BUBBLE) && (i_rd != 5'd0);

  always_comb begin
    in_wstrb = 4'b0000;
    in_wdata = 32'd0;
    if (is_store) begin
      case (i_func3[1:0])
        2'b00: begin
          in_wstrb = 4'b0001 << i_result[1:0];
          in_wdata = {4{i_data_store[7:0]}};
        end
        2'b01: begin
          in_wstrb = i_result[1] ? 4'b1100 : 4'b0011;
          in_wdata = {2{i_data_store[15:0]}};
        end
        default: begin
          in_wstrb = 4'b1111;
          in_wdata = i_data_store;
        end
      endcase
    end
  end

  always_comb begin
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_addr  = 32'd0;
    o_dmem_wdata = 32'd0;
    o_dmem_wstrb = 4'b0000;
    if (state == WAIT) begin
      o_dmem_req   = 1'b1;
      o_dmem_we    = lat_we;
      o_dmem_addr  = lat_addr;
      o_dmem_wdata = lat_wdata;
      o_dmem_wstrb = lat_wstrb;
    end else if (in_go) begin
      o_dmem_req   = 1'b1;
      o_dmem_we    = is_store;
      o_dmem_addr  = {i_result[31:2], 2'b00};
      o_dmem_wdata = in_wdata;
      o_dmem_wstrb = in_wstrb;
    end
  end

  assign o_stall   = ((state == WAIT) || in_go) && !i_dmem_ack;
  assign o_rd_mem  = o_wb_we ? o_wb_rd : 5'd0;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_addr    <= 32'd0;
      lat_wdata   <= 32'd0;
      lat_wstrb   <= 4'b0000;
      lat_we      <= 1'b0;
      lat_lo      <= 2'b00;
      lat_f3      <= 3'b000;
      lat_rd      <= 5'd0;
      lat_pc      <= 32'd0;
      o_wb_result <= 32'd0;
      o_wb_rd     <= 5'd0;
      o_wb_we     <= 1'b0;
      o_wb_pc     <= 32'd0;
      o_fault     <= 1'b0;
    end else begin
      o_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (!is_mem) begin
            o_wb_result <= i_result;
            o_wb_rd     <= i_rd;
            o_wb_pc     <= i_pc;
            o_wb_we     <= in_wb_we;
          end else if (in_fault) begin
            o_wb_we <= 1'b0;
            o_fault <= 1'b1;
          end else if (i_dmem_ack) begin
            o_wb_rd <= i_rd;
            o_wb_pc <= i_pc;
            if (is_store) begin
              o_wb_we <= 1'b0;
            end else begin
              o_wb_result <= extract(i_func3, i_result[1:0], i_dmem_rdata);
              o_wb_we     <= (i_rd != 5'd0);
            end
          end else begin
            lat_addr  <= {i_result[31:2], 2'b00};
            lat_wdata <= in_wdata;
            lat_wstrb <= in_wstrb;
            lat_we    <= is_store;
            lat_lo    <= i_result[1:0];
            lat_f3    <= i_func3;
            lat_rd    <= i_rd;
            lat_pc    <= i_pc;
            cnt       <= '0;
            o_wb_we   <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (i_dmem_ack) begin
            o_wb_rd <= lat_rd;
            o_wb_pc <= lat_pc;
            if (lat_we) begin
              o_wb_we <= 1'b0;
            end else begin
              o_wb_result <= extract(lat_f3, lat_lo, i_dmem_rdata);
              o_wb_we     <= (lat_rd != 5'd0);
            end
            state <= IDLE;
          end else begin
            o_wb_we <= 1'b0;
            // The IDLE issue cycle is the first wait cycle, so the abort lands
            // after TIMEOUT stall cycles in total.
            if ((cnt + 1'b1) == CNT_LAST) begin
              o_fault <= 1'b1;
              state   <= IDLE;
            end else if (cnt != CNT_LAST) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: drivers push expected write-back entries,
// a negedge monitor pops and compares whenever the DUT retires a result or fault.
module tb_memory_access;

  localparam int W = 44;  // {fault, we, rd, rd_mem, result}
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ADD    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_result = '0, i_data_store = '0, i_pc = '0, i_dmem_rdata = '0;
  logic [2:0]  i_func3 = '0;
  logic [6:0]  i_opcode = '0;
  logic [4:0]  i_rd = '0;
  logic        i_dmem_ack = 1'b0;
  logic        o_dmem_req, o_dmem_we, o_stall, o_wb_we, o_fault, dbg_state;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_result, o_wb_pc;
  logic [3:0]  o_dmem_wstrb;
  logic [4:0]  o_wb_rd, o_rd_mem;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  memory_access #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .i_result(i_result), .i_data_store(i_data_store),
    .i_pc(i_pc), .i_func3(i_func3), .i_opcode(i_opcode), .i_rd(i_rd),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata), .o_stall(o_stall),
    .o_wb_result(o_wb_result), .o_wb_rd(o_wb_rd), .o_wb_we(o_wb_we),
    .o_wb_pc(o_wb_pc), .o_rd_mem(o_rd_mem), .o_fault(o_fault), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    if (!rst && (o_wb_we || o_fault)) begin
      act = o_fault ? {1'b1, o_wb_we, 42'd0} : {1'b0, 1'b1, o_wb_rd, o_rd_mem, o_wb_result};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got %h expected nothing", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL wb_entry: got %h expected %h", act, exp);
        end
      end
    end
  end

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] res);
    exp_q.push_back({1'b0, 1'b1, rd, rd, res});
  endtask

  task automatic push_fault();
    exp_q.push_back({1'b1, 1'b0, 42'd0});
  endtask

  // driver tasks
  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                        input logic [31:0] data, input logic [4:0] rd, input logic [31:0] pc);
    i_opcode = op; i_func3 = f3; i_result = res; i_data_store = data; i_rd = rd; i_pc = pc;
  endtask

  task automatic bubble();
    set_in(7'd0, 3'd0, 32'd0, 32'd0, 5'd0, 32'd0);
    i_dmem_ack = 1'b0;
  endtask

  task automatic alu_op(input logic [6:0] op, input logic [31:0] res, input logic [4:0] rd,
                        input logic [31:0] pc, input logic exp_we);
    @(posedge clk); #1;
    set_in(op, 3'd0, res, 32'd0, rd, pc);
    i_dmem_ack = 1'b0;
    if (exp_we) push_wb(rd, res);
    @(negedge clk);
    chk("alu_req", o_dmem_req, 0);
    chk("alu_stall", o_stall, 0);
  endtask

  task automatic mem_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd, input logic [31:0] pc,
                        input int wait_n, input logic [31:0] rdata, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic exp_wb_we,
                        input logic [31:0] exp_res);
    @(posedge clk); #1;
    set_in(op, f3, addr, data, rd, pc);
    i_dmem_rdata = rdata;
    if (exp_wb_we) push_wb(rd, exp_res);
    for (int k = 0; k <= wait_n; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      i_dmem_ack = (k == wait_n);
      @(negedge clk);
      chk("mem_stall", o_stall, (k < wait_n) ? 32'd1 : 32'd0);
      chk("mem_req", o_dmem_req, 1);
      chk("mem_we", o_dmem_we, (op == OP_STORE) ? 32'd1 : 32'd0);
      chk("mem_addr", o_dmem_addr, {addr[31:2], 2'b00});
      chk("mem_wstrb", o_dmem_wstrb, exp_strb);
      chk("mem_wdata", o_dmem_wdata, exp_wdata);
    end
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    chk("mem_wb_we", o_wb_we, exp_wb_we);
  endtask

  task automatic fault_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd);
    @(posedge clk); #1;
    set_in(op, f3, addr, 32'h5555_5555, rd, 32'h0000_0300);
    i_dmem_ack = 1'b1;  // an ack with no request must be ignored
    push_fault();
    @(negedge clk);
    chk("fault_req", o_dmem_req, 0);
    chk("fault_stall", o_stall, 0);
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    chk("fault_wb_we", o_wb_we, 0);
  endtask

  task automatic timeout_op();
    int stalls;
    @(posedge clk); #1;
    set_in(OP_LOAD, 3'b010, 32'h0000_4000, 32'd0, 5'd12, 32'h0000_0400);
    i_dmem_ack = 1'b0;
    push_fault();
    stalls = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      if (o_stall && o_dmem_req) stalls++;
    end
    chk("timeout_stall_cycles", stalls, 16);
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    chk("timeout_stall_after", o_stall, 0);
    chk("timeout_state_idle", dbg_state, 0);
    chk("timeout_req_after", o_dmem_req, 0);
  endtask

  task automatic reset_in_wait();
    @(posedge clk); #1;
    set_in(OP_LOAD, 3'b001, 32'h0000_3002, 32'd0, 5'd13, 32'h0000_0500);
    i_dmem_ack = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("rst_pre_req", o_dmem_req, 1);
    rst = 1'b1;
    #1;
    chk("rst_req_drop", o_dmem_req, 0);
    chk("rst_state", dbg_state, 0);
    bubble();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wb_result", o_wb_result, 0);
    chk("rst_wb_rd", o_wb_rd, 0);
    chk("rst_wb_we", o_wb_we, 0);
    chk("rst_wb_pc", o_wb_pc, 0);
    chk("rst_rd_mem", o_rd_mem, 0);
    chk("rst_fault", o_fault, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_req", o_dmem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bubble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_wb_we", o_wb_we, 0);
    chk("reset_wb_result", o_wb_result, 0);
    chk("reset_fault", o_fault, 0);
    chk("reset_req", o_dmem_req, 0);
    chk("reset_state", dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    alu_op(OP_ADD, 32'h0000_1234, 5'd5, 32'h0000_0100, 1'b1);
    alu_op(OP_LUI, 32'hABCD_E000, 5'd31, 32'h0000_0104, 1'b1);
    alu_op(OP_BRANCH, 32'h0000_0001, 5'd3, 32'h0000_0108, 1'b0);
    alu_op(OP_ADD, 32'h0000_7777, 5'd0, 32'h0000_010C, 1'b0);

    mem_op(OP_STORE, 3'b000, 32'h0000_1002, 32'h0000_00AB, 5'd0, 32'h0000_0200, 0,
           32'd0, 4'b0100, 32'hABAB_ABAB, 1'b0, 32'd0);
    mem_op(OP_STORE, 3'b001, 32'h0000_1006, 32'h1234_CDEF, 5'd0, 32'h0000_0204, 1,
           32'd0, 4'b1100, 32'hCDEF_CDEF, 1'b0, 32'd0);
    mem_op(OP_STORE, 3'b010, 32'h0000_2000, 32'hDEAD_BEEF, 5'd0, 32'h0000_0208, 0,
           32'd0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'd0);
    mem_op(OP_LOAD, 3'b000, 32'h0000_1003, 32'd0, 5'd7, 32'h0000_020C, 3,
           32'h8012_3456, 4'b0000, 32'd0, 1'b1, 32'hFFFF_FF80);
    mem_op(OP_LOAD, 3'b100, 32'h0000_1003, 32'd0, 5'd8, 32'h0000_0210, 3,
           32'h8012_3456, 4'b0000, 32'd0, 1'b1, 32'h0000_0080);
    mem_op(OP_LOAD, 3'b000, 32'h0000_1001, 32'd0, 5'd14, 32'h0000_0214, 0,
           32'h1234_5678, 4'b0000, 32'd0, 1'b1, 32'h0000_0056);
    mem_op(OP_LOAD, 3'b001, 32'h0000_2002, 32'd0, 5'd9, 32'h0000_0218, 0,
           32'h8001_7FFE, 4'b0000, 32'd0, 1'b1, 32'hFFFF_8001);
    mem_op(OP_LOAD, 3'b101, 32'h0000_2002, 32'd0, 5'd10, 32'h0000_021C, 2,
           32'h8001_7FFE, 4'b0000, 32'd0, 1'b1, 32'h0000_8001);
    mem_op(OP_LOAD, 3'b001, 32'h0000_2000, 32'd0, 5'd15, 32'h0000_0220, 1,
           32'h8001_7FFE, 4'b0000, 32'd0, 1'b1, 32'h0000_7FFE);
    mem_op(OP_LOAD, 3'b010, 32'h0000_3000, 32'd0, 5'd11, 32'h0000_0224, 1,
           32'hCAFE_F00D, 4'b0000, 32'd0, 1'b1, 32'hCAFE_F00D);
    mem_op(OP_LOAD, 3'b010, 32'h0000_3000, 32'd0, 5'd0, 32'h0000_0228, 0,
           32'hCAFE_F00D, 4'b0000, 32'd0, 1'b0, 32'd0);

    fault_op(OP_LOAD, 3'b010, 32'h0000_1002, 5'd6);
    fault_op(OP_LOAD, 3'b001, 32'h0000_1001, 5'd6);
    fault_op(OP_LOAD, 3'b011, 32'h0000_1000, 5'd6);
    fault_op(OP_STORE, 3'b100, 32'h0000_1000, 5'd0);

    timeout_op();
    alu_op(OP_ADD, 32'h0000_0042, 5'd4, 32'h0000_0600, 1'b1);
    reset_in_wait();
    alu_op(OP_ADD, 32'h0000_0099, 5'd2, 32'h0000_0700, 1'b1);

    @(posedge clk); #1;
    bubble();
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
